// File: rtl/output_ram_scheduler_pkg.sv
// Shared types and sizes for the output-controller frame RAM scheduler.
//   ADDR_W / DATA_W : frame RAM address and word widths
//   BUF_DEPTH       : entries in the output word buffer
//   CNT_W / PTR_W   : buffer occupancy and index widths
//   oc_state_t      : scan sequencer states
package output_ctrl_pkg;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 32;
    localparam int BUF_DEPTH = 3;
    localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W     = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } oc_state_t;
endpackage

// File: rtl/output_ram_scheduler_if.sv
// Bundle of everything the scheduler exchanges with the raster writer,
// the frame RAM and the output serializer.
//   master : the scheduler side (drives acks, stream, RAM ports)
//   slave  : the environment side (writer, serializer, RAM)
interface output_ram_scheduler_if;
    import output_ctrl_pkg::*;

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              start;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_d;
    logic [ADDR_W-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_q;

    modport master (
        input  wr_req, wr_addr, wr_data, start, out_ready, ram_q,
        output wr_ack, busy, done, out_valid, out_data,
               ram_we, ram_waddr, ram_d, ram_raddr
    );

    modport slave (
        output wr_req, wr_addr, wr_data, start, out_ready, ram_q,
        input  wr_ack, busy, done, out_valid, out_data,
               ram_we, ram_waddr, ram_d, ram_raddr
    );
endinterface

// File: rtl/output_ram_scheduler_fifo.sv
// output_word_fifo: small synchronous FIFO holding scanned words until the
// serializer takes them.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data this cycle (ignored when full and not popping)
//   push_data  : word to store
//   pop        : drop the head word (ignored when empty)
//   count      : words currently held
//   head       : oldest word; reads as zero after reset
module output_word_fifo
    import output_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head
);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(BUF_DEPTH);
    localparam logic [PTR_W-1:0] LAST_IX = PTR_W'(BUF_DEPTH - 1);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_idx_q, wr_idx_d;
    logic [PTR_W-1:0]  rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        return (idx == LAST_IX) ? '0 : idx + PTR_W'(1);
    endfunction

    always_comb begin
        pop_ok   = pop & (count_q != '0);
        push_ok  = push & ((count_q != FULL) | pop_ok);
        wr_idx_d = push_ok ? next_idx(wr_idx_q) : wr_idx_q;
        rd_idx_d = pop_ok  ? next_idx(rd_idx_q) : rd_idx_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_idx_q] <= push_data;
            end
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_idx_q];
endmodule

// File: rtl/output_ram_scheduler.sv
// Frame RAM scheduler: passes raster writes straight to the RAM write port
// and, on start, scans addresses 0..DEPTH-1 out through a small buffer as a
// valid/ready stream. A read that would collide with a same-cycle write to
// the same address is held back one cycle so the word carries the new data.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : writer, stream and RAM signals (output_ram_scheduler_if.master)
//   DEPTH    : words per frame, 1..128
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing RAM reads while buffer credit allows
// DRAIN | all reads issued, waiting for the buffer to empty
module output_ram_scheduler
    import output_ctrl_pkg::*;
#(
    parameter int DEPTH = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    output_ram_scheduler_if.master bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        CREDITS   = 3'(BUF_DEPTH);

    oc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              pop, hazard, credit, issue, drained;
    logic [2:0]        occupancy;

    assign bus.wr_ack    = bus.wr_req & ~rst;
    assign bus.ram_we    = bus.wr_req & ~rst;
    assign bus.ram_waddr = bus.wr_addr;
    assign bus.ram_d     = bus.wr_data;
    assign bus.ram_raddr = rd_ptr_q;

    assign pop = bus.out_valid & bus.out_ready;

    // The word leaving this cycle frees its slot now, which keeps the
    // stream at one word per cycle with only three entries.
    assign occupancy = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign credit    = occupancy < CREDITS;
    assign hazard    = bus.wr_req & (bus.wr_addr == rd_ptr_q);
    assign drained   = (fifo_count == '0) & ~inflight_q & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SCAN;
            SCAN:    if (issue && rd_ptr_q == LAST_ADDR) state_d = DRAIN;
            DRAIN:   if (drained) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue    = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state_q)
            SCAN: begin
                bus.busy = 1'b1;
                issue    = credit & ~hazard;
            end
            DRAIN: begin
                bus.busy = 1'b1;
                bus.done = drained;
            end
            default: ;
        endcase
    end

    // rd_ptr wraps naturally at DEPTH=128; the state change to DRAIN stops
    // any further issue from the wrapped value.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        inflight_d = issue;
        if (state_q == IDLE && bus.start) begin
            rd_ptr_d = '0;
        end else if (issue) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    output_word_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data (bus.ram_q),
        .pop       (pop),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_data  = fifo_head;
endmodule

// File: tb/tb_output_ram_scheduler.sv
module tb_output_ram_scheduler;
    import output_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_ram_scheduler_if a_if ();
    output_ram_scheduler_if b_if ();

    output_ram_scheduler #(.DEPTH(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    output_ram_scheduler #(.DEPTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    // Frame RAM models: registered read, old data on same-address read-during-write.
    logic [31:0] mem_a [128];
    logic [31:0] mem_b [128];
    always @(posedge clk) begin
        if (a_if.ram_we) mem_a[a_if.ram_waddr] <= a_if.ram_d;
        a_if.ram_q <= mem_a[a_if.ram_raddr];
        if (b_if.ram_we) mem_b[b_if.ram_waddr] <= b_if.ram_d;
        b_if.ram_q <= mem_b[b_if.ram_raddr];
    end

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] shadow [128];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Exact-timing scan against the start-latency rules; hz injects one hazard
    // on address 10 while the DEPTH=128 block is about to read it.
    task automatic timed_scan(input bit hz);
        int          last_done;
        bit          exp_valid;
        int          k;
        last_done = hz ? 132 : 131;
        for (int n = 0; n <= 136; n++) begin
            a_if.start     = (n == 0) || (n == 50);
            b_if.start     = !hz && (n == 0 || n == 2);
            a_if.wr_req    = hz && (n == 11);
            a_if.wr_addr   = 7'd10;
            a_if.wr_data   = 32'hDEADBEEF;
            if (hz && n == 11) shadow[10] = 32'hDEADBEEF;
            @(negedge clk);
            if (!hz) begin
                exp_valid = (n >= 3 && n <= 130);
                k = n - 3;
            end else begin
                exp_valid = (n >= 3 && n <= 12) || (n >= 14 && n <= 131);
                k = (n <= 12) ? n - 3 : n - 4;
            end
            chk("a_valid", a_if.out_valid, exp_valid);
            if (exp_valid) chk("a_data", a_if.out_data, shadow[k]);
            chk("a_done", a_if.done, n == last_done);
            chk("a_busy", a_if.busy, n >= 1 && n <= last_done);
            if (hz && n == 11) begin
                chk("hz_raddr", a_if.ram_raddr, 32'd10);
                chk("hz_wr_ack", a_if.wr_ack, 1'b1);
            end
            if (!hz) begin
                chk("b_valid", b_if.out_valid, n == 3);
                if (n == 3) chk("b_data", b_if.out_data, 32'hCAFEF00D);
                chk("b_done", b_if.done, n == 4);
                chk("b_busy", b_if.busy, n >= 1 && n <= 4);
            end
            next_cycle();
        end
        a_if.start  = 1'b0;
        b_if.start  = 1'b0;
        a_if.wr_req = 1'b0;
    endtask

    // Scoreboarded scan: mode 0 ready always, 1 ready pattern 1,0,0,1,
    // 2 random ready plus random writes to addresses whose outcome is known
    // (well ahead of anything that can have been read, or already delivered).
    task automatic sb_scan(input int mode, input string tag);
        int          r = 0;
        int          dones = 0;
        int          last_hs = -1;
        int          done_cyc = -1;
        bit          stalled = 1'b0;
        logic [31:0] held = '0;
        int          wa;
        for (int n = 0; n < 3000; n++) begin
            a_if.start = (n == 0);
            case (mode)
                0:       a_if.out_ready = 1'b1;
                1:       a_if.out_ready = (n % 4 == 0) || (n % 4 == 3);
                default: a_if.out_ready = ($urandom_range(3, 0) != 0);
            endcase
            a_if.wr_req = 1'b0;
            if (mode == 2 && $urandom_range(2, 0) == 0) begin
                wa = -1;
                if (r + 4 <= 127 && $urandom_range(1, 0) == 1) wa = int'($urandom_range(127, r + 4));
                else if (r > 0 && r <= 128) wa = int'($urandom_range(r - 1, 0));
                if (wa >= 0) begin
                    a_if.wr_req  = 1'b1;
                    a_if.wr_addr = 7'(wa);
                    a_if.wr_data = $urandom;
                    shadow[wa]   = a_if.wr_data;
                end
            end
            @(negedge clk);
            if (stalled) begin
                chk({tag, "_hold_valid"}, a_if.out_valid, 1'b1);
                chk({tag, "_hold_data"}, a_if.out_data, held);
            end
            if (a_if.out_valid && a_if.out_ready) begin
                if (r < 128) chk({tag, "_data"}, a_if.out_data, shadow[r]);
                r++;
                last_hs = n;
            end
            if (a_if.done) begin
                dones++;
                done_cyc = n;
            end
            stalled = a_if.out_valid && !a_if.out_ready;
            held    = a_if.out_data;
            next_cycle();
            if (dones > 0 && n > done_cyc + 3) break;
        end
        a_if.start     = 1'b0;
        a_if.wr_req    = 1'b0;
        a_if.out_ready = 1'b1;
        chk({tag, "_words"}, r, 32'd128);
        chk({tag, "_dones"}, dones, 32'd1);
        chk({tag, "_done_gap"}, done_cyc, last_hs + 1);
        @(negedge clk);
        chk({tag, "_idle"}, a_if.busy, 1'b0);
        next_cycle();
    endtask

    initial begin
        rst = 1'b1;
        a_if.wr_req = 1'b1; a_if.wr_addr = '0; a_if.wr_data = '0;
        a_if.start = 1'b0;  a_if.out_ready = 1'b1;
        b_if.wr_req = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0;
        b_if.start = 1'b0;  b_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", a_if.busy, 1'b0);
        chk("rst_done", a_if.done, 1'b0);
        chk("rst_valid", a_if.out_valid, 1'b0);
        chk("rst_data", a_if.out_data, 32'h0);
        chk("rst_raddr", a_if.ram_raddr, 32'h0);
        chk("rst_wr_ack", a_if.wr_ack, 1'b0);
        chk("rst_ram_we", a_if.ram_we, 1'b0);
        chk("rst_b_busy", b_if.busy, 1'b0);
        next_cycle();
        rst = 1'b0;

        for (int a = 0; a < 128; a++) begin
            a_if.wr_req  = 1'b1;
            a_if.wr_addr = 7'(a);
            a_if.wr_data = 32'(a) * 32'h01010101;
            shadow[a]    = a_if.wr_data;
            b_if.wr_req  = (a == 0);
            b_if.wr_addr = '0;
            b_if.wr_data = 32'hCAFEF00D;
            @(negedge clk);
            chk("pre_wr_ack", a_if.wr_ack, 1'b1);
            if (a == 5) begin
                chk("pre_waddr", a_if.ram_waddr, 32'd5);
                chk("pre_wd", a_if.ram_d, 32'h05050505);
            end
            next_cycle();
        end
        a_if.wr_req = 1'b0;
        b_if.wr_req = 1'b0;

        timed_scan(1'b0);
        timed_scan(1'b1);
        sb_scan(1, "bp");
        sb_scan(2, "rnd1");
        sb_scan(2, "rnd2");

        a_if.out_ready = 1'b1;
        for (int n = 0; n < 43; n++) begin
            a_if.start = (n == 0);
            @(negedge clk);
            chk("abort_no_done", a_if.done, 1'b0);
            next_cycle();
        end
        a_if.start  = 1'b0;
        rst         = 1'b1;
        a_if.wr_req = 1'b1;
        @(negedge clk);
        chk("abort_busy", a_if.busy, 1'b0);
        chk("abort_valid", a_if.out_valid, 1'b0);
        chk("abort_data", a_if.out_data, 32'h0);
        chk("abort_raddr", a_if.ram_raddr, 32'h0);
        chk("abort_wr_ack", a_if.wr_ack, 1'b0);
        chk("abort_ram_we", a_if.ram_we, 1'b0);
        for (int n = 0; n < 3; n++) begin
            next_cycle();
            @(negedge clk);
            chk("abort_done", a_if.done, 1'b0);
        end
        next_cycle();
        rst         = 1'b0;
        a_if.wr_req = 1'b0;
        next_cycle();
        sb_scan(0, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
